enemy_formation_ctrl: RTL

- Parametrised movement controller for the invader formation: owns formation origin, direction, speed ramp and end-of-game flags.
- Enemy pixel positions are derived downstream as origin + column/row offsets; this block no longer keeps per-enemy coordinate arrays.
- Sits between the game state machine (drives run/restart, consumes hit_bottom/all_dead) and the per-enemy sprite instances (consume origin).
- Adds alive-aware edge tracking, a bottom-limit loss condition, a speed clamp and a single-cycle step strobe.

---
 rtl/formation_pkg.sv | 21 ++
 rtl/formation_extent.sv | 50 +++++
 rtl/enemy_formation_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/formation_pkg.sv
// Shared types and defaults for the invader formation: FSM states, direction codes, grid size.
package formation_pkg;

    localparam int ROWS_DEF = 4;
    localparam int COLS_DEF = 10;

    typedef enum logic [1:0] {
        MOVE_H  = 2'd0,
        DESCEND = 2'd1,
        HALT    = 2'd2
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Index widths must stay >= 1 bit even for a single row/column.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/formation_extent.sv
// Combinational reduction of the alive mask to the occupied column span and lowest occupied row.
// With no enemy alive, all indices report 0 and any_alive_o is low.
module formation_extent
    import formation_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF,
    parameter int CW   = clog2_min1(COLS),
    parameter int RW   = clog2_min1(ROWS)
) (
    input  logic [ROWS*COLS-1:0] alive_i,
    output logic [CW-1:0]        lcol_o,
    output logic [CW-1:0]        rcol_o,
    output logic [RW-1:0]        brow_o,
    output logic                 any_alive_o
);

    logic [COLS-1:0] col_any;
    logic [ROWS-1:0] row_any;

    always_comb begin
        col_any = '0;
        row_any = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                col_any[c] = col_any[c] | alive_i[r*COLS+c];
                row_any[r] = row_any[r] | alive_i[r*COLS+c];
            end
        end
    end

    // Last match wins: scan down for the lowest column, up for the highest.
    always_comb begin
        lcol_o = '0;
        rcol_o = '0;
        brow_o = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_any[c]) lcol_o = CW'(c);
        end
        for (int c = 0; c < COLS; c++) begin
            if (col_any[c]) rcol_o = CW'(c);
        end
        for (int r = 0; r < ROWS; r++) begin
            if (row_any[r]) brow_o = RW'(r);
        end
    end

    assign any_alive_o = |row_any;

endmodule

// File: rtl/enemy_formation_ctrl.sv
// Invader formation movement: origin, direction, speed ramp, bottom/all-dead halting.
// Optional FORMATION_KILL_SPEEDUP_EN adds kill-count speed boost on top of the descent ramp.
module enemy_formation_ctrl
    import formation_pkg::*;
#(
    parameter int ROWS       = ROWS_DEF,
    parameter int COLS       = COLS_DEF,
    parameter int XW         = 11,
    parameter int YW         = 10,
    parameter int X0         = 150,
    parameter int Y0         = 40,
    parameter int DX_COL     = 30,
    parameter int DY_ROW     = 30,
    parameter int STAGGER    = 10,
    parameter int X_MIN      = 150,
    parameter int X_MAX      = 760,
    parameter int Y_LIMIT    = 440,
    parameter int STEP_DIV   = 2097152,
    parameter int DELTA_X    = 1,
    parameter int DELTA_Y    = 50,
    parameter int MAX_SPEED  = 15,
    parameter int KILL_SHIFT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart,
    input  logic                 run,
    input  logic [ROWS*COLS-1:0] alive,
    output logic [XW-1:0]        origin_x,
    output logic [YW-1:0]        origin_y,
    output logic                 direction,
    output logic [4:0]           speed,
    output logic                 step_pulse,
    output logic                 hit_bottom,
    output logic                 all_dead
);

    localparam int CW   = clog2_min1(COLS);
    localparam int RW   = clog2_min1(ROWS);
    localparam int EW   = XW + 2;
    localparam int YEW  = YW + 2;
    localparam int CNTW = clog2_min1(STEP_DIV);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(STEP_DIV - 1);

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [XW-1:0]   origin_x_q, origin_x_d;
    logic [YW-1:0]   origin_y_q, origin_y_d;
    logic            dir_q, dir_d;
    logic [4:0]      speed_q, speed_d;
    logic            pulse_q, pulse_d;
    logic            hit_q, hit_d;
    logic            dead_q, dead_d;

    logic [CW-1:0]   lcol, rcol;
    logic [RW-1:0]   brow;
    logic            any_alive;

    formation_extent #(
        .ROWS (ROWS),
        .COLS (COLS),
        .CW   (CW),
        .RW   (RW)
    ) u_extent (
        .alive_i     (alive),
        .lcol_o      (lcol),
        .rcol_o      (rcol),
        .brow_o      (brow),
        .any_alive_o (any_alive)
    );

    logic [4:0] speed_eff;

`ifdef FORMATION_KILL_SPEEDUP_EN
    logic [15:0] live_cnt;
    logic [15:0] kills;
    logic [15:0] boosted;

    always_comb begin
        live_cnt = '0;
        for (int i = 0; i < ROWS*COLS; i++) begin
            live_cnt = live_cnt + 16'(alive[i]);
        end
        kills     = 16'(ROWS*COLS) - live_cnt;
        boosted   = 16'(speed_q) + (kills >> KILL_SHIFT);
        speed_eff = (boosted > 16'(MAX_SPEED)) ? 5'(MAX_SPEED) : boosted[4:0];
    end
`else
    assign speed_eff = speed_q;
`endif

    logic [EW-1:0]  step;
    logic [EW-1:0]  right_edge, left_edge;
    logic [YEW-1:0] bottom_y;
    logic           can_right, can_left, move_ok, bottom_hit, halted, tick;

    assign step       = EW'(DELTA_X) + EW'(speed_eff);
    assign right_edge = EW'(origin_x_q) + EW'(rcol) * EW'(DX_COL) + EW'(STAGGER);
    assign left_edge  = EW'(origin_x_q) + EW'(lcol) * EW'(DX_COL);
    assign can_right  = (right_edge + step) <= EW'(X_MAX);
    // Threshold moved to the right-hand side so the left check never underflows.
    assign can_left   = left_edge >= (EW'(X_MIN) + step);
    assign move_ok    = (dir_q == DIR_RIGHT) ? can_right : can_left;
    assign bottom_y   = YEW'(origin_y_q) + YEW'(brow) * YEW'(DY_ROW);
    assign bottom_hit = any_alive && (bottom_y >= YEW'(Y_LIMIT));
    assign halted     = (state_q == HALT);
    assign tick       = run && !halted && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state_q    <= MOVE_H;
            cnt_q      <= '0;
            origin_x_q <= XW'(X0);
            origin_y_q <= YW'(Y0);
            dir_q      <= DIR_RIGHT;
            speed_q    <= '0;
            pulse_q    <= 1'b0;
            hit_q      <= 1'b0;
            dead_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            origin_x_q <= origin_x_d;
            origin_y_q <= origin_y_d;
            dir_q      <= dir_d;
            speed_q    <= speed_d;
            pulse_q    <= pulse_d;
            hit_q      <= hit_d;
            dead_q     <= dead_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MOVE_H:  if (tick && !move_ok) state_d = DESCEND;
            DESCEND: if (tick) state_d = MOVE_H;
            default: state_d = HALT;
        endcase
        // A same-cycle tick still lands its move; only later ticks are suppressed.
        if (!halted && (bottom_hit || !any_alive)) state_d = HALT;
    end

    always_comb begin
        cnt_d      = cnt_q;
        origin_x_d = origin_x_q;
        origin_y_d = origin_y_q;
        dir_d      = dir_q;
        speed_d    = speed_q;
        pulse_d    = 1'b0;
        hit_d      = hit_q;
        dead_d     = dead_q;
        if (!halted) begin
            if (run) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNTW'(1);
            hit_d  = bottom_hit;
            dead_d = !any_alive;
            if (tick) begin
                if (state_q == DESCEND) begin
                    origin_y_d = origin_y_q + YW'(DELTA_Y);
                    speed_d    = (speed_q >= 5'(MAX_SPEED)) ? 5'(MAX_SPEED) : speed_q + 5'd1;
                    pulse_d    = 1'b1;
                end else if (move_ok) begin
                    origin_x_d = (dir_q == DIR_RIGHT) ? origin_x_q + step[XW-1:0]
                                                      : origin_x_q - step[XW-1:0];
                    pulse_d    = 1'b1;
                end else begin
                    dir_d = ~dir_q;
                end
            end
        end
    end

    assign origin_x   = origin_x_q;
    assign origin_y   = origin_y_q;
    assign direction  = dir_q;
    assign speed      = speed_eff;
    assign step_pulse = pulse_q;
    assign hit_bottom = hit_q;
    assign all_dead   = dead_q;

endmodule
